serial_disp_ctrl: RTL
=====================

# serial_disp_ctrl

Scheduler for the board's two serial display chains: the 7-segment shift chain (seg_*) and the LED shift chain (led_*). It accepts frame-update requests from two requesters and arbitrates one shared shift engine between them. For the granted chain it generates the serial clock, data and latch/enable sequence. It sits between the display-data logic and the board display pins, next to the button and switch front end.

## Interface
- SEG_BITS, 64, 7-seg frame length in bits
- LED_BITS, 16, LED frame length in bits (≤ SEG_BITS)
- CLK_DIV, 2, half-period of the generated serial clock in clk_100mhz cycles (≥1)

- clk_100mhz  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- seg_req  in  1  level request to send seg_data
- seg_data  in  SEG_BITS  7-seg frame, held stable until seg_ack
- seg_ack  out  1  one-cycle pulse; seg_data captured this cycle
- led_req  in  1  level request to send led_data
- led_data  in  LED_BITS  LED frame, held stable until led_ack
- led_ack  out  1  one-cycle pulse; led_data captured this cycle
- seg_clk, seg_sout, SEG_PEN, seg_clrn  out  1 each  7-seg chain clock, data, output enable, clear (active-low)
- led_clk, led_sout, LED_PEN, led_clrn  out  1 each  LED chain equivalents
- busy  out  1  shift engine not in IDLE

## Operation
- FSM states:
  - IDLE: arbitrate.
  - SHIFT: N bits serialised.
  - LATCH: one cycle.
  - Return to IDLE.
- IDLE with ≥1 request: grant one chain.
  - Pulse its ack.
  - Load the shift register; the LED frame is left-aligned, N = LED_BITS.
  - Drive that chain's PEN low, go to SHIFT.
- Only one chain is active at a time. The inactive chain's clk and sout are held 0, and its PEN keeps its current value.
- SHIFT, MSB first. For each bit:
  - sout = current MSB.
  - clk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - Shift left at the end of the high phase.
- After bit N-1's high phase: clk = 0, sout = 0, go to LATCH.
- LATCH: raise the chain's PEN (held high until its next grant), then go to IDLE.
- A request deasserted before its ack: no transfer, no ack.
- A request still high after its ack requests a new frame. It is eligible in the next IDLE.
- clrn outputs: 0 while rst is asserted. Registered to 1 on the first clk_100mhz edge after rst falls. They never toggle otherwise.

## Timing
- Reset values:
  - seg_ack = led_ack = busy = 0
  - all clk/sout = 0
  - SEG_PEN = LED_PEN = 0
  - seg_clrn = led_clrn = 0
  - FSM = IDLE
  - round-robin pointer = seg
- Grant cycle: ack = 1, busy = 1 from the next cycle.
- Frame duration from ack to IDLE is 1 + N·2·CLK_DIV + 1 cycles.
  - Seg at default: 258 cycles.
  - LED at default: 66 cycles.
- Back-to-back frames: the next ack comes in the first IDLE cycle, with no extra gap.
- Reset mid-frame:
  - All outputs return to reset values immediately (asynchronous).
  - The partial frame is discarded and not re-acked.
  - The requester must re-request.
- A request held through reset is granted in the first cycle after release (ack in cycle 1).
- Simultaneous requests in IDLE: resolved by the arbitration policy (Configuration).

## Configuration
- P2S_RR_ARB_EN defined: round-robin.
  - The pointer toggles to the other chain after each grant.
  - With both requesting continuously, grants alternate seg, led, seg, …
- Undefined: fixed priority, seg over led.
  - led is granted only when seg_req = 0 in IDLE.
  - Continuous seg_req starves led by design.

## Structure
- Shared package p2s_pkg:
  - FSM state enum (IDLE, SHIFT, LATCH).
  - Chain-select enum (CH_SEG, CH_LED).
  - Default width constants.
- Sub-module p2s_shifter: SEG_BITS-wide shift register, bit counter and CLK_DIV phase counter.
  - Inputs: load, len, start.
  - Outputs: sclk, sdata, done.
- The top level holds the arbiter, FSM and output steering.

## Test plan
- Reset release, no requests → all outputs 0 except clrn = 1 after the first edge; busy stays 0.
- seg_req with seg_data = 64'h8000_0000_0000_0001, CLK_DIV = 2:
  - seg_ack in the grant cycle.
  - 64 seg_clk rising edges; sout = 1 at the first and last edge, 0 otherwise.
  - SEG_PEN rises 257 cycles after ack.
  - IDLE after 258 cycles.
- led_data = 16'hA5A5 → led_sout sampled on led_clk rising edges yields 1010_0101_1010_0101. seg_* stay idle.
- Both requests held, P2S_RR_ARB_EN defined → ack order seg, led, seg, led. Undefined → seg acked every frame, led never.
- rst asserted at bit 20 of a seg frame → outputs reset asynchronously. After release with seg_req held, ack arrives at cycle 1 and a full 64-bit frame is sent.
- Request dropped one cycle before its grant opportunity → no ack, busy stays 0.

Source files
------------

// File: rtl/p2s_pkg.sv
// p2s_pkg
//   Shared definitions for the serial display scheduler (serial_disp_ctrl)
//   and its shift engine (p2s_shifter).
//
//   Contents:
//     - default frame widths and serial clock divider
//     - FSM state encodings (IDLE, SHIFT, LATCH), kept as plain constants so
//       older tools and waveform viewers see a simple 2-bit code
//     - chain-select enum (CH_SEG, CH_LED) and a helper returning the
//       opposite chain
package p2s_pkg;

    localparam int SEG_BITS_DEF = 64;
    localparam int LED_BITS_DEF = 16;
    localparam int CLK_DIV_DEF  = 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    typedef enum logic {
        CH_SEG = 1'b0,
        CH_LED = 1'b1
    } chan_e;

    function automatic chan_e other_chan(input chan_e c);
        return (c == CH_SEG) ? CH_LED : CH_SEG;
    endfunction

endpackage

// File: rtl/serial_disp_ctrl_if.sv
// serial_disp_ctrl_if
//   Frame-update handshake between the display-data logic (master) and the
//   serial display scheduler (slave).
//
//   Signals:
//     seg_req   level request to send seg_data
//     seg_data  7-segment frame, held stable until seg_ack
//     seg_ack   one-cycle pulse, seg_data captured in this cycle
//     led_req   level request to send led_data
//     led_data  LED frame, held stable until led_ack
//     led_ack   one-cycle pulse, led_data captured in this cycle
interface serial_disp_ctrl_if
    import p2s_pkg::*;
#(
    parameter int SEG_BITS = SEG_BITS_DEF,
    parameter int LED_BITS = LED_BITS_DEF
);

    logic                seg_req;
    logic [SEG_BITS-1:0] seg_data;
    logic                seg_ack;
    logic                led_req;
    logic [LED_BITS-1:0] led_data;
    logic                led_ack;

    modport master (
        output seg_req, seg_data, led_req, led_data,
        input  seg_ack, led_ack
    );

    modport slave (
        input  seg_req, seg_data, led_req, led_data,
        output seg_ack, led_ack
    );

endinterface

// File: rtl/p2s_shifter.sv
// p2s_shifter
//   Shared shift engine: a WIDTH-bit MSB-first shift register with a bit
//   counter and a CLK_DIV phase counter that produce the serial clock.
//
//   Ports:
//     clk, rst   system clock, asynchronous active-high reset
//     start      one-cycle pulse: capture load/len and begin shifting
//     load       frame data, left-aligned (first bit in the MSB)
//     len        number of bits to send (1..WIDTH)
//     sclk       serial clock: low CLK_DIV cycles, then high CLK_DIV cycles
//     sdata      current MSB while shifting, 0 otherwise
//     done       high in the last cycle of the last bit's high phase
module p2s_shifter
    import p2s_pkg::*;
#(
    parameter int WIDTH   = SEG_BITS_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int LEN_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load,
    input  logic [LEN_W-1:0] len,
    output logic             sclk,
    output logic             sdata,
    output logic             done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [LEN_W-1:0] bits_left_q, bits_left_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             high_q, high_d;
    logic             active_q, active_d;
    logic             phase_end;

    assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        sreg_d      = sreg_q;
        bits_left_d = bits_left_q;
        div_d       = div_q;
        high_d      = high_q;
        active_d    = active_q;
        if (start) begin
            sreg_d      = load;
            bits_left_d = len;
            div_d       = '0;
            high_d      = 1'b0;
            active_d    = (len != '0);
        end else if (active_q) begin
            if (phase_end) begin
                div_d = '0;
                if (!high_q) begin
                    high_d = 1'b1;
                end else begin
                    // End of a bit: advance to the next MSB.
                    high_d      = 1'b0;
                    sreg_d      = sreg_q << 1;
                    bits_left_d = bits_left_q - LEN_W'(1);
                    if (bits_left_q == LEN_W'(1)) begin
                        active_d = 1'b0;
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q      <= '0;
            bits_left_q <= '0;
            div_q       <= '0;
            high_q      <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            sreg_q      <= sreg_d;
            bits_left_q <= bits_left_d;
            div_q       <= div_d;
            high_q      <= high_d;
            active_q    <= active_d;
        end
    end

    assign sclk  = active_q & high_q;
    assign sdata = active_q & sreg_q[WIDTH-1];
    assign done  = active_q & high_q & phase_end & (bits_left_q == LEN_W'(1));

endmodule

// File: rtl/serial_disp_ctrl.sv
// serial_disp_ctrl
//   Schedules frame updates for the 7-segment and LED shift chains over one
//   shared shift engine: arbitrates the two requesters, serialises the
//   granted frame MSB first, then raises that chain's output enable.
//
//   Ports:
//     clk_100mhz            system clock
//     rst                   asynchronous active-high reset
//     req_if (slave)        seg/led request, data and ack handshake
//     seg_clk, seg_sout     7-seg chain serial clock and data
//     SEG_PEN, seg_clrn     7-seg chain output enable and clear (active low)
//     led_clk, led_sout     LED chain serial clock and data
//     LED_PEN, led_clrn     LED chain output enable and clear (active low)
//     busy                  shift engine not idle
//
//   Configuration macro:
//     P2S_RR_ARB_EN  defined   round-robin arbitration between the chains
//                    undefined fixed priority, seg over led
module serial_disp_ctrl
    import p2s_pkg::*;
#(
    parameter int SEG_BITS = SEG_BITS_DEF,
    parameter int LED_BITS = LED_BITS_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF
) (
    input  logic                clk_100mhz,
    input  logic                rst,
    serial_disp_ctrl_if.slave   req_if,
    output logic                seg_clk,
    output logic                seg_sout,
    output logic                SEG_PEN,
    output logic                seg_clrn,
    output logic                led_clk,
    output logic                led_sout,
    output logic                LED_PEN,
    output logic                led_clrn,
    output logic                busy
);

    localparam int LEN_W = $clog2(SEG_BITS + 1);

    logic [1:0]          state_q, state_d;
    chan_e               sel_q, sel_d;
    logic                seg_pen_q, seg_pen_d;
    logic                led_pen_q, led_pen_d;
    logic                clrn_q;
    logic                grant_seg, grant_led, start;
    logic [SEG_BITS-1:0] load_data;
    logic [LEN_W-1:0]    load_len;
    logic                sh_sclk, sh_sdata, sh_done;

`ifdef P2S_RR_ARB_EN
    chan_e               ptr_q, ptr_d;
`endif

    // Arbitration only happens in IDLE and only once reset has been released
    // for at least one edge, so acks stay low while rst is asserted.
    always_comb begin
        grant_seg = 1'b0;
        grant_led = 1'b0;
        if (state_q == IDLE && clrn_q) begin
`ifdef P2S_RR_ARB_EN
            if (req_if.seg_req && req_if.led_req) begin
                grant_seg = (ptr_q == CH_SEG);
                grant_led = (ptr_q == CH_LED);
            end else begin
                grant_seg = req_if.seg_req;
                grant_led = req_if.led_req;
            end
`else
            grant_seg = req_if.seg_req;
            grant_led = req_if.led_req & ~req_if.seg_req;
`endif
        end
    end

    assign start = grant_seg | grant_led;

    // The LED frame is left-aligned so the engine always shifts from its MSB.
    always_comb begin
        load_data = req_if.seg_data;
        load_len  = LEN_W'(SEG_BITS);
        if (grant_led) begin
            load_data = SEG_BITS'(req_if.led_data) << (SEG_BITS - LED_BITS);
            load_len  = LEN_W'(LED_BITS);
        end
    end

`ifdef P2S_RR_ARB_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant_seg) ptr_d = other_chan(CH_SEG);
        if (grant_led) ptr_d = other_chan(CH_LED);
    end
`endif

    // Frame sequencing: a grant drops the chosen chain's PEN and starts the
    // engine; the engine's last high phase moves to LATCH, where that PEN is
    // raised and kept high until the chain's next grant.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        seg_pen_d = seg_pen_q;
        led_pen_d = led_pen_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    if (grant_led) begin
                        sel_d     = CH_LED;
                        led_pen_d = 1'b0;
                    end else begin
                        sel_d     = CH_SEG;
                        seg_pen_d = 1'b0;
                    end
                end
            end
            SHIFT: begin
                if (sh_done) begin
                    state_d = LATCH;
                    if (sel_q == CH_LED) led_pen_d = 1'b1;
                    else                 seg_pen_d = 1'b1;
                end
            end
            LATCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= CH_SEG;
            seg_pen_q <= 1'b0;
            led_pen_q <= 1'b0;
            clrn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            seg_pen_q <= seg_pen_d;
            led_pen_q <= led_pen_d;
            clrn_q    <= 1'b1;
        end
    end

`ifdef P2S_RR_ARB_EN
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) ptr_q <= CH_SEG;
        else     ptr_q <= ptr_d;
    end
`endif

    p2s_shifter #(
        .WIDTH   (SEG_BITS),
        .CLK_DIV (CLK_DIV),
        .LEN_W   (LEN_W)
    ) u_shifter (
        .clk   (clk_100mhz),
        .rst   (rst),
        .start (start),
        .load  (load_data),
        .len   (load_len),
        .sclk  (sh_sclk),
        .sdata (sh_sdata),
        .done  (sh_done)
    );

    assign req_if.seg_ack = grant_seg;
    assign req_if.led_ack = grant_led;

    // The engine's outputs are already 0 outside SHIFT, so steering by the
    // selected chain keeps the idle chain's clk/sout at 0.
    assign seg_clk  = sh_sclk  & (sel_q == CH_SEG);
    assign seg_sout = sh_sdata & (sel_q == CH_SEG);
    assign led_clk  = sh_sclk  & (sel_q == CH_LED);
    assign led_sout = sh_sdata & (sel_q == CH_LED);
    assign SEG_PEN  = seg_pen_q;
    assign LED_PEN  = led_pen_q;
    assign seg_clrn = clrn_q;
    assign led_clrn = clrn_q;
    assign busy     = (state_q != IDLE);

endmodule
